// File: rtl/nco_mc_tdm.sv
// Time-division-multiplexed NCO: NC channels share one quarter-wave sine ROM.
// One tagged sin/cos sample per enabled clock, fixed 6-cycle latency.
module nco_mc_tdm #(
  parameter int APR    = 32,
  parameter int MPR    = 16,
  parameter int LAW    = 10,
  parameter int NC     = 4,
  parameter int LOG2NC = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  cfg_wr,
  input  logic                  cfg_sel,
  input  logic [LOG2NC-1:0]     cfg_chan,
  input  logic [APR-1:0]        cfg_data,
  input  logic                  sync_i,
  output logic signed [MPR-1:0] fsin_o,
  output logic signed [MPR-1:0] fcos_o,
  output logic [LOG2NC-1:0]     out_chan,
  output logic                  out_valid
);
  localparam int N   = 1 << LAW;
  localparam int ENT = 1 << LOG2NC;
  localparam logic [MPR-2:0] MAX = '1;

  function automatic logic [MPR-2:0] rom_val(input int k);
    real x;
    x = (2.0 ** (MPR - 1) - 1.0) * $sin(3.14159265358979323846 / 2.0 * real'(k) / real'(N));
    return (MPR-1)'($rtoi(x + 0.5));
  endfunction

  logic [MPR-2:0] rom [N];
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom[k] = rom_val(k);
  end

  logic [LOG2NC-1:0] chan_q, chan_d;
  logic [APR-1:0]    acc_q [ENT];
  logic [APR-1:0]    acc_d [ENT];
  logic [APR-1:0]    inc_q [ENT];
  logic [APR-1:0]    inc_d [ENT];
  logic [APR-1:0]    off_q [ENT];
  logic [APR-1:0]    off_d [ENT];

  // Stage 1 keeps only the phase bits that survive truncation.
  logic [LAW+1:0]        s1_phase_q, s1_phase_d;
  logic [1:0]            s2_qs_q, s2_qs_d, s2_qc_q, s2_qc_d;
  logic [LAW-1:0]        s2_a_q, s2_a_d;
  logic [LAW-1:0]        s3_addr_s_q, s3_addr_s_d, s3_addr_c_q, s3_addr_c_d;
  logic [1:0]            s3_max_q, s3_max_d, s3_neg_q, s3_neg_d;
  logic [1:0]            s4_max_q, s4_neg_q, s5_neg_q;
  logic [MPR-2:0]        s4_rom_s_q, s4_rom_c_q;
  logic [MPR-2:0]        s5_mag_s_q, s5_mag_s_d, s5_mag_c_q, s5_mag_c_d;
  logic signed [MPR-1:0] s6_sin_q, s6_sin_d, s6_cos_q, s6_cos_d;
  logic [LOG2NC-1:0]     chan_sr_q [6];
  logic [5:0]            vld_sr_q;

  always_comb begin
    chan_d = (chan_q == LOG2NC'(NC - 1)) ? '0 : chan_q + LOG2NC'(1);
    s1_phase_d = (LAW+2)'((acc_q[chan_q] + off_q[chan_q]) >> (APR - LAW - 2));
    for (int i = 0; i < ENT; i++) begin
      acc_d[i] = acc_q[i];
      inc_d[i] = inc_q[i];
      off_d[i] = off_q[i];
    end
    if (sync_i) begin
      for (int i = 0; i < ENT; i++) acc_d[i] = '0;
    end else begin
      acc_d[chan_q] = acc_q[chan_q] + inc_q[chan_q];
    end
    if (cfg_wr && (32'(cfg_chan) < 32'(NC))) begin
      if (cfg_sel) off_d[cfg_chan] = cfg_data;
      else         inc_d[cfg_chan] = cfg_data;
    end
  end

  // Bit 0 of the paired flags is the sine path, bit 1 the cosine path.
  always_comb begin
    s2_qs_d     = s1_phase_q[LAW+1 -: 2];
    s2_qc_d     = s2_qs_d + 2'd1;
    s2_a_d      = s1_phase_q[LAW-1:0];
    s3_addr_s_d = s2_qs_q[0] ? LAW'(0) - s2_a_q : s2_a_q;
    s3_addr_c_d = s2_qc_q[0] ? LAW'(0) - s2_a_q : s2_a_q;
    s3_max_d    = {s2_qc_q[0] && (s2_a_q == '0), s2_qs_q[0] && (s2_a_q == '0)};
    s3_neg_d    = {s2_qc_q[1], s2_qs_q[1]};
    s5_mag_s_d  = s4_max_q[0] ? MAX : s4_rom_s_q;
    s5_mag_c_d  = s4_max_q[1] ? MAX : s4_rom_c_q;
    s6_sin_d    = s5_neg_q[0] ? $signed(MPR'(0) - {1'b0, s5_mag_s_q}) : $signed({1'b0, s5_mag_s_q});
    s6_cos_d    = s5_neg_q[1] ? $signed(MPR'(0) - {1'b0, s5_mag_c_q}) : $signed({1'b0, s5_mag_c_q});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chan_q <= '0;
      for (int i = 0; i < ENT; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= '0;
        off_q[i] <= '0;
      end
      s1_phase_q  <= '0;
      s2_qs_q     <= '0;
      s2_qc_q     <= '0;
      s2_a_q      <= '0;
      s3_addr_s_q <= '0;
      s3_addr_c_q <= '0;
      s3_max_q    <= '0;
      s3_neg_q    <= '0;
      s4_max_q    <= '0;
      s4_neg_q    <= '0;
      s4_rom_s_q  <= '0;
      s4_rom_c_q  <= '0;
      s5_neg_q    <= '0;
      s5_mag_s_q  <= '0;
      s5_mag_c_q  <= '0;
      s6_sin_q    <= '0;
      s6_cos_q    <= '0;
      for (int i = 0; i < 6; i++) chan_sr_q[i] <= '0;
      vld_sr_q    <= '0;
    end else if (clken) begin
      chan_q <= chan_d;
      for (int i = 0; i < ENT; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
        off_q[i] <= off_d[i];
      end
      s1_phase_q  <= s1_phase_d;
      s2_qs_q     <= s2_qs_d;
      s2_qc_q     <= s2_qc_d;
      s2_a_q      <= s2_a_d;
      s3_addr_s_q <= s3_addr_s_d;
      s3_addr_c_q <= s3_addr_c_d;
      s3_max_q    <= s3_max_d;
      s3_neg_q    <= s3_neg_d;
      s4_max_q    <= s3_max_q;
      s4_neg_q    <= s3_neg_q;
      s4_rom_s_q  <= rom[s3_addr_s_q];
      s4_rom_c_q  <= rom[s3_addr_c_q];
      s5_neg_q    <= s4_neg_q;
      s5_mag_s_q  <= s5_mag_s_d;
      s5_mag_c_q  <= s5_mag_c_d;
      s6_sin_q    <= s6_sin_d;
      s6_cos_q    <= s6_cos_d;
      chan_sr_q[0] <= chan_q;
      for (int i = 1; i < 6; i++) chan_sr_q[i] <= chan_sr_q[i-1];
      vld_sr_q    <= {vld_sr_q[4:0], 1'b1};
    end
  end

  assign fsin_o    = s6_sin_q;
  assign fcos_o    = s6_cos_q;
  assign out_chan  = chan_sr_q[5];
  assign out_valid = vld_sr_q[5];

endmodule

// File: tb/tb_nco_mc_tdm.sv
// Directed bench for nco_mc_tdm: one single-channel and one four-channel
// instance sharing clock, reset, enable and config strobes.
module tb_nco_mc_tdm;
  logic clk = 1'b0;
  logic reset_n, clken, cfg_wr, cfg_sel, sync_i;
  logic [0:0] cfg_chan1;
  logic [1:0] cfg_chan4;
  logic [31:0] cfg_data;
  logic signed [15:0] fsin1, fcos1, fsin4, fcos4;
  logic [0:0] chan1;
  logic [1:0] chan4;
  logic vld1, vld4;
  int errors = 0;
  int checks = 0;
  int sin_tbl [16] = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                       0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};

  always #5 clk = ~clk;

  nco_mc_tdm #(.NC(1), .LOG2NC(1)) u_nc1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_chan(cfg_chan1), .cfg_data(cfg_data), .sync_i(sync_i),
    .fsin_o(fsin1), .fcos_o(fcos1), .out_chan(chan1), .out_valid(vld1));

  nco_mc_tdm #(.NC(4), .LOG2NC(2)) u_nc4 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_chan(cfg_chan4), .cfg_data(cfg_data), .sync_i(sync_i),
    .fsin_o(fsin4), .fcos_o(fcos4), .out_chan(chan4), .out_valid(vld4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input int v, input int s, input int c);
    check({tag, " valid"}, {31'b0, vld1}, v);
    check({tag, " chan"}, {31'b0, chan1}, 0);
    check({tag, " sin"}, fsin1, s);
    check({tag, " cos"}, fcos1, c);
  endtask

  task automatic chk4(input string tag, input int v, input int ch, input int s, input int c);
    check({tag, " valid"}, {31'b0, vld4}, v);
    check({tag, " chan"}, {30'b0, chan4}, ch);
    check({tag, " sin"}, fsin4, s);
    check({tag, " cos"}, fcos4, c);
  endtask

  task automatic cfg(input logic sel, input logic [1:0] ch, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_chan4 = ch; cfg_chan1 = ch[0]; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  initial begin
    int ch, es, ec;
    reset_n = 1'b0; clken = 1'b1; cfg_wr = 1'b0; cfg_sel = 1'b0;
    cfg_chan1 = '0; cfg_chan4 = '0; cfg_data = '0; sync_i = 1'b0;

    // Single channel: reset state, latency, offsets.
    tick();
    chk1("nc1 reset", 0, 0, 0);
    chk4("nc4 reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (5) tick();
    check("nc1 valid at 5", {31'b0, vld1}, 0);
    tick();
    chk1("nc1 first", 1, 0, 32767);
    repeat (3) begin
      tick();
      chk1("nc1 steady", 1, 0, 32767);
    end
    cfg(1'b1, 2'd1, 32'h4000_0000);
    cfg(1'b1, 2'd0, 32'h4000_0000);
    repeat (5) tick();
    chk1("nc1 old off", 1, 0, 32767);
    tick();
    chk1("nc1 off 90", 1, 32767, 0);
    cfg(1'b1, 2'd0, 32'h8000_0000);
    repeat (6) tick();
    chk1("nc1 off 180", 1, 0, -32767);

    // Single channel sweep, period 16.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cfg(1'b0, 2'd0, 32'h1000_0000);
    repeat (6) tick();
    for (int s = 0; s < 20; s++) begin
      if (s > 0) tick();
      chk1($sformatf("nc1 sweep s%0d", s), 1, sin_tbl[s % 16], sin_tbl[(s + 4) % 16]);
    end

    // Four channels: offsets, increment, sync, same-visit write.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cfg(1'b1, 2'd1, 32'h4000_0000);
    cfg(1'b1, 2'd2, 32'h8000_0000);
    cfg(1'b1, 2'd3, 32'hC000_0000);
    cfg(1'b0, 2'd1, 32'h0100_0000);
    tick();
    for (int e = 6; e <= 32; e++) begin
      sync_i = (e == 16);
      if (e == 19) begin
        cfg_wr = 1'b1; cfg_sel = 1'b0; cfg_chan4 = 2'd2; cfg_chan1 = 1'b0; cfg_data = 32'h0200_0000;
      end
      tick();
      sync_i = 1'b0;
      cfg_wr = 1'b0;
      ch = (e - 6) % 4;
      case (ch)
        0:       begin es = 0;      ec = 32767;  end
        1:       begin es = 32767;  ec = 0;      end
        2:       begin es = 0;      ec = -32767; end
        default: begin es = -32767; ec = 0;      end
      endcase
      case (e)
        15, 27: begin es = 32757; ec = -804;   end
        19, 31: begin es = 32728; ec = -1608;  end
        32:     begin es = -1608; ec = -32728; end
        default: ;
      endcase
      chk4($sformatf("nc4 stream e%0d", e), 1, ch, es, ec);
    end

    // Clock-enable freeze and resume.
    clken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk4($sformatf("nc4 freeze %0d", i), 1, 2, -1608, -32728);
    end
    clken = 1'b1;
    tick();
    chk4("nc4 resume e33", 1, 3, -32767, 0);
    tick();
    chk4("nc4 resume e34", 1, 0, 0, 32767);
    tick();
    check("nc4 resume e35 chan", {30'b0, chan4}, 1);

    // Reset mid-stream with clken low.
    reset_n = 1'b0;
    clken = 1'b0;
    tick();
    chk4("nc4 mid reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    clken = 1'b1;
    repeat (5) tick();
    check("nc4 valid at 5", {31'b0, vld4}, 0);
    tick();
    chk4("nc4 restart ch0", 1, 0, 0, 32767);
    tick();
    chk4("nc4 restart ch1", 1, 1, 0, 32767);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
